// File: rtl/sm3_ch_arb.sv
// Shares one SM3 core between CH_NUM message requesters; grant is locked per message until its digest returns.
// Build option: SM3_ARB_FIX_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module sm3_ch_arb #(
    parameter int CH_NUM = 4,
    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CH_NUM*32-1:0]   ch_msg_d,
    input  logic [CH_NUM*4-1:0]    ch_msg_vld_byte,
    input  logic [CH_NUM-1:0]      ch_msg_vld,
    input  logic [CH_NUM-1:0]      ch_msg_lst,
    output logic [CH_NUM-1:0]      ch_msg_rdy,
    output logic [31:0]            core_msg_d,
    output logic [3:0]             core_msg_vld_byte,
    output logic                   core_msg_vld,
    output logic                   core_msg_lst,
    input  logic                   core_msg_rdy,
    input  logic [255:0]           core_res,
    input  logic                   core_res_vld,
    output logic [255:0]           res_d,
    output logic [CH_NUM-1:0]      res_vld,
    output logic [CW-1:0]          res_ch,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER     = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [CW-1:0]       grant_reg;
    logic [CW-1:0]       ptr;
    logic [CW-1:0]       arb_win;
    logic                arb_found;
    logic [CW:0]         arb_idx;
    logic [255:0]        res_d_reg;
    logic [CH_NUM-1:0]   res_vld_reg;
    logic [CW-1:0]       res_ch_reg;

    logic [31:0]         ch_d  [CH_NUM];
    logic [3:0]          ch_vb [CH_NUM];

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_unpack
            assign ch_d[gi]  = ch_msg_d[32*gi +: 32];
            assign ch_vb[gi] = ch_msg_vld_byte[4*gi +: 4];
        end
    endgenerate

    logic [31:0] sel_d;
    logic [3:0]  sel_vb;
    logic        sel_vld;
    logic        sel_lst;
    logic        xfer_fire;
    logic        res_done;

    assign sel_d     = ch_d[grant_reg];
    assign sel_vb    = ch_vb[grant_reg];
    assign sel_vld   = ch_msg_vld[grant_reg];
    assign sel_lst   = ch_msg_lst[grant_reg];
    assign xfer_fire = (state_reg == XFER) && sel_vld && core_msg_rdy;
    assign res_done  = (state_reg == WAIT_RES) && core_res_vld;

    // Rotating search starting at ptr; with ptr held at 0 this degenerates to fixed priority.
    always_comb begin
        arb_win   = '0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            arb_idx = {1'b0, ptr} + (CW+1)'(i);
            if (arb_idx >= (CW+1)'(CH_NUM))
                arb_idx = arb_idx - (CW+1)'(CH_NUM);
            if (!arb_found && ch_msg_vld[arb_idx[CW-1:0]]) begin
                arb_found = 1'b1;
                arb_win   = arb_idx[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (|ch_msg_vld)             state_next = XFER;
            XFER:     if (xfer_fire && sel_lst)    state_next = WAIT_RES;
            WAIT_RES: if (core_res_vld)            state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    always_comb begin
        core_msg_d        = '0;
        core_msg_vld_byte = '0;
        core_msg_vld      = 1'b0;
        core_msg_lst      = 1'b0;
        ch_msg_rdy        = '0;
        busy              = (state_reg != IDLE);
        if (state_reg == XFER) begin
            core_msg_d              = sel_d;
            core_msg_vld_byte       = sel_vb;
            core_msg_vld            = sel_vld;
            core_msg_lst            = sel_lst;
            ch_msg_rdy[grant_reg]   = core_msg_rdy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            grant_reg <= '0;
        else if (state_reg == IDLE && (|ch_msg_vld))
            grant_reg <= arb_win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_d_reg   <= '0;
            res_vld_reg <= '0;
            res_ch_reg  <= '0;
        end else begin
            res_vld_reg <= '0;
            if (res_done) begin
                res_d_reg   <= core_res;
                res_ch_reg  <= grant_reg;
                res_vld_reg <= CH_NUM'(1) << grant_reg;
            end
        end
    end

`ifdef SM3_ARB_FIX_PRIO_EN
    assign ptr = '0;
`else
    logic [CW-1:0] ptr_reg;

    // Next search starts just past the channel that was served last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_reg <= '0;
        else if (res_done)
            ptr_reg <= (grant_reg == CW'(CH_NUM-1)) ? '0 : grant_reg + CW'(1);
    end

    assign ptr = ptr_reg;
`endif

    assign res_d   = res_d_reg;
    assign res_vld = res_vld_reg;
    assign res_ch  = res_ch_reg;

endmodule

// File: tb/tb_sm3_ch_arb.sv
// Bench for sm3_ch_arb: per-channel sources, a stub core returning known digests, and a scoreboard monitor.
module tb_sm3_ch_arb;
    localparam int CH = 4;
    localparam int CW = 2;
    localparam logic [255:0] D_ABC  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] D_16   = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
    localparam logic [255:0] D_JUNK = 256'hdead_beef;
    localparam logic [31:0]  W_ABC  = 32'h61626300;
    localparam logic [31:0]  W_ABCD = 32'h61626364;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [CH*32-1:0] ch_msg_d;
    logic [CH*4-1:0]  ch_msg_vld_byte;
    logic [CH-1:0]    ch_msg_vld, ch_msg_lst, ch_msg_rdy;
    logic [31:0]      core_msg_d;
    logic [3:0]       core_msg_vld_byte;
    logic             core_msg_vld, core_msg_lst;
    logic             core_msg_rdy = 1'b1;
    logic [255:0]     core_res = '0;
    logic             core_res_vld = 1'b0;
    logic [255:0]     res_d;
    logic [CH-1:0]    res_vld;
    logic [CW-1:0]    res_ch;
    logic             busy;

    logic [31:0] src_d  [CH];
    logic [3:0]  src_vb [CH];
    logic        src_vld[CH];
    logic        src_lst[CH];

    always_comb begin
        ch_msg_d = '0; ch_msg_vld_byte = '0; ch_msg_vld = '0; ch_msg_lst = '0;
        for (int k = 0; k < CH; k++) begin
            ch_msg_d[32*k +: 32]       = src_d[k];
            ch_msg_vld_byte[4*k +: 4]  = src_vb[k];
            ch_msg_vld[k]              = src_vld[k];
            ch_msg_lst[k]              = src_lst[k];
        end
    end

    sm3_ch_arb #(.CH_NUM(CH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_msg_d(ch_msg_d), .ch_msg_vld_byte(ch_msg_vld_byte),
        .ch_msg_vld(ch_msg_vld), .ch_msg_lst(ch_msg_lst), .ch_msg_rdy(ch_msg_rdy),
        .core_msg_d(core_msg_d), .core_msg_vld_byte(core_msg_vld_byte),
        .core_msg_vld(core_msg_vld), .core_msg_lst(core_msg_lst), .core_msg_rdy(core_msg_rdy),
        .core_res(core_res), .core_res_vld(core_res_vld),
        .res_d(res_d), .res_vld(res_vld), .res_ch(res_ch), .busy(busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm, input logic [255:0] act);
        n_chk++;
        $display("FAIL %s: got %0h expected nothing", nm, act);
    endtask

    // Scoreboard: per-channel expected beats, expected grant order, expected results.
    logic [36:0]  exp_beat[CH][64];
    int           wr_i[CH];
    int           rd_i[CH];
    int           exp_grant[$];
    int           exp_rch[$];
    logic [255:0] exp_rd[$];
    int           owner = -1;
    bit           wait_ph = 0;
    int           proto_err = 0;

    always @(negedge clk) begin : monitor
        int ch;
        int e_ch;
        logic [255:0] e_d;
        if (!rst_n) begin
            owner = -1;
            wait_ph = 0;
        end else begin
            if ($countones(ch_msg_rdy) > 1) proto_err++;
            if (owner >= 0 && (ch_msg_rdy & ~(4'b0001 << owner)) != 0) proto_err++;
            if (wait_ph && core_msg_vld) proto_err++;
            if (core_msg_vld && core_msg_rdy) begin
                ch = owner;
                if (owner < 0) begin
                    if (exp_grant.size() == 0) begin
                        fail_now("unexpected_grant", ch_msg_rdy);
                        ch = -1;
                    end else begin
                        ch = exp_grant.pop_front();
                    end
                end
                if (ch >= 0) begin
                    chk($sformatf("rdy_route_ch%0d", ch), ch_msg_rdy, 4'b0001 << ch);
                    if (rd_i[ch] < wr_i[ch]) begin
                        chk($sformatf("beat_ch%0d_%0d", ch, rd_i[ch]),
                            {core_msg_lst, core_msg_vld_byte, core_msg_d}, exp_beat[ch][rd_i[ch] % 64]);
                        rd_i[ch]++;
                    end else begin
                        fail_now($sformatf("extra_beat_ch%0d", ch), core_msg_d);
                    end
                    owner = ch;
                    if (core_msg_lst) wait_ph = 1;
                end
            end
            if (res_vld != 0) begin
                if (exp_rch.size() == 0) begin
                    fail_now("unexpected_res_vld", res_vld);
                end else begin
                    e_ch = exp_rch.pop_front();
                    e_d  = exp_rd.pop_front();
                    chk("res_vld", res_vld, 4'b0001 << e_ch);
                    chk("res_ch", res_ch, e_ch);
                    chk("res_d", res_d, e_d);
                    chk("protocol", proto_err, 0);
                    proto_err = 0;
                end
                owner = -1;
                wait_ph = 0;
            end
        end
    end

    // Stub core: counts beats per message and returns a known digest a few cycles after lst.
    int core_cnt = 0;
    int core_cd = 0;
    logic [255:0] core_dig = '0;
    bit spur = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            core_cnt = 0; core_cd = 0; core_res_vld = 0; spur = 0;
        end else begin
            core_res_vld = 0;
            if (spur) begin
                core_res = D_JUNK; core_res_vld = 1; spur = 0;
            end
            if (core_cd > 0) begin
                core_cd--;
                if (core_cd == 0) begin core_res = core_dig; core_res_vld = 1; end
            end
            if (core_msg_vld && core_msg_rdy) begin
                core_cnt++;
                if (core_msg_lst) begin
                    core_dig = (core_cnt == 1) ? D_ABC : (core_cnt == 16) ? D_16 : D_JUNK;
                    core_cnt = 0;
                    core_cd = 4;
                end
            end
        end
    end

    bit rdy_mode = 0;
    int rdy_cyc = 0;
    initial forever begin
        @(posedge clk); #1;
        rdy_cyc++;
        core_msg_rdy = rdy_mode ? (rdy_cyc % 3 == 0) : 1'b1;
    end

    // Called aligned to posedge+1; each beat waits for its own handshake.
    task automatic send(input int ch, input int nw, input logic [31:0] w, input logic [3:0] lastvb,
                        input int gap_at, input int gap_len);
        for (int i = 0; i < nw; i++) begin
            bit lst;
            bit got;
            int tmo;
            logic [3:0] vb;
            lst = (i == nw - 1);
            vb  = lst ? lastvb : 4'hf;
            exp_beat[ch][wr_i[ch] % 64] = {lst, vb, w};
            wr_i[ch]++;
            if (gap_len > 0 && i == gap_at) begin
                src_vld[ch] = 0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            src_d[ch] = w; src_vb[ch] = vb; src_lst[ch] = lst; src_vld[ch] = 1;
            got = 0; tmo = 0;
            while (!got && tmo < 500) begin
                @(negedge clk);
                got = ch_msg_rdy[ch];
                @(posedge clk); #1;
                tmo++;
            end
            if (!got) begin
                chk($sformatf("beat_timeout_ch%0d", ch), got, 1'b1);
                break;
            end
        end
        src_vld[ch] = 0; src_lst[ch] = 0; src_d[ch] = '0; src_vb[ch] = '0;
    endtask

    task automatic wait_idle();
        int tmo = 0;
        bit done = 0;
        while (!done && tmo < 3000) begin
            @(negedge clk);
            done = (exp_rch.size() == 0) && !busy;
            @(posedge clk); #1;
            tmo++;
        end
        if (!done) chk("wait_idle_timeout", exp_rch.size(), 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk); rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic expect_msg(input int ch, input logic [255:0] d);
        exp_grant.push_back(ch);
        exp_rch.push_back(ch);
        exp_rd.push_back(d);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ch_msg_rdy"}, ch_msg_rdy, 0);
        chk({tag, "_core_msg"}, {core_msg_vld, core_msg_lst, core_msg_vld_byte, core_msg_d}, 0);
        chk({tag, "_res_vld"}, res_vld, 0);
        chk({tag, "_res_ch"}, res_ch, 0);
        chk({tag, "_res_d"}, res_d, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < CH; k++) begin
            src_d[k] = '0; src_vb[k] = '0; src_vld[k] = 0; src_lst[k] = 0;
            wr_i[k] = 0; rd_i[k] = 0;
        end
        #1 rst_n = 0;
        #10 check_reset_outputs("por");
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Single 'abc' on ch2.
        expect_msg(2, D_ABC);
        send(2, 1, W_ABC, 4'b1110, -1, 0);
        wait_idle();
        $display("tb: abc on ch2 done");

        // 16-word message on ch1 with a throttled core.
        rdy_mode = 1;
        expect_msg(1, D_16);
        send(1, 16, W_ABCD, 4'hf, -1, 0);
        wait_idle();
        rdy_mode = 0;
        $display("tb: 16-word on ch1 done");

        // All four channels at once from reset.
        reset_pulse();
        for (int k = 0; k < CH; k++) expect_msg(k, D_ABC);
        fork
            send(0, 1, W_ABC, 4'b1110, -1, 0);
            send(1, 1, W_ABC, 4'b1110, -1, 0);
            send(2, 1, W_ABC, 4'b1110, -1, 0);
            send(3, 1, W_ABC, 4'b1110, -1, 0);
        join
        wait_idle();
        $display("tb: four-way contention done");

        // Pointer wrapped past ch3: ch0 ahead of ch3.
        expect_msg(0, D_ABC);
        expect_msg(3, D_ABC);
        fork
            send(0, 1, W_ABC, 4'b1110, -1, 0);
            send(3, 1, W_ABC, 4'b1110, -1, 0);
        join
        wait_idle();
        $display("tb: ch0/ch3 contention done");

        // ch0 stalls mid-message while ch1 waits.
        expect_msg(0, D_16);
        expect_msg(1, D_ABC);
        fork
            send(0, 16, W_ABCD, 4'hf, 6, 5);
            begin
                repeat (3) @(posedge clk);
                #1;
                send(1, 1, W_ABC, 4'b1110, -1, 0);
            end
        join
        wait_idle();
        $display("tb: ch0 stall with ch1 pending done");

        // ch1 just served: round-robin favours ch2, fixed priority favours ch1.
`ifdef SM3_ARB_FIX_PRIO_EN
        expect_msg(1, D_ABC);
        expect_msg(2, D_ABC);
`else
        expect_msg(2, D_ABC);
        expect_msg(1, D_ABC);
`endif
        fork
            send(1, 1, W_ABC, 4'b1110, -1, 0);
            send(2, 1, W_ABC, 4'b1110, -1, 0);
        join
        wait_idle();
        $display("tb: ch1/ch2 contention done");

        // Stray core_res_vld while idle must be ignored.
        spur = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("spur_idle_busy", busy, 0);
        $display("tb: stray result in idle done");

        // Reset in the middle of a ch2 message, with a stray result during XFER first.
        rdy_mode = 1;
        exp_grant.push_back(2);
        for (int i = 0; i < 16; i++) begin
            exp_beat[2][wr_i[2] % 64] = {1'b0, 4'hf, W_ABCD};
            wr_i[2]++;
        end
        src_d[2] = W_ABCD; src_vb[2] = 4'hf; src_lst[2] = 0; src_vld[2] = 1;
        repeat (4) @(posedge clk);
        #1 spur = 1;
        repeat (6) @(posedge clk);
        chk("mid_xfer_busy", busy, 1);
        @(negedge clk);
        #2 rst_n = 0;
        #1 check_reset_outputs("async_rst");
        src_vld[2] = 0; src_d[2] = '0; src_vb[2] = '0;
        rd_i[2] = wr_i[2];
        repeat (2) @(negedge clk);
        rst_n = 1;
        rdy_mode = 0;
        @(posedge clk); #1;
        expect_msg(2, D_ABC);
        send(2, 1, W_ABC, 4'b1110, -1, 0);
        wait_idle();
        $display("tb: reset mid-message and retry done");

        for (int k = 0; k < CH; k++) chk($sformatf("beats_left_ch%0d", k), wr_i[k] - rd_i[k], 0);
        chk("grants_left", exp_grant.size(), 0);
        chk("results_left", exp_rch.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sm3_ch_arb.md
Name: sm3_ch_arb

Overview:
Multi-channel front-end arbiter for sm3_core_top. It shares one SM3 core between CH_NUM independent message requesters. Each grant is locked for a whole message: from the first accepted beat through the beat carrying lst, then until the core returns its digest. The digest is routed back to the owning channel with a channel tag. The block sits between the per-channel message sources and the core's msg_inpt_*/cmprss_otpt_* interface, 32-bit input mode (SM3_INPT_DW_32).

Parameters:
CH_NUM, 4, number of requester channels (2..8)
CW, (CH_NUM>1 ? $clog2(CH_NUM) : 1), channel index width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ch_msg_d  in  CH_NUM*32  per-channel message word, channel k at [32k+:32]
ch_msg_vld_byte  in  CH_NUM*4  per-channel byte valid, MSB-first, channel k at [4k+:4]
ch_msg_vld  in  CH_NUM  per-channel word valid
ch_msg_lst  in  CH_NUM  per-channel last word of message
ch_msg_rdy  out  CH_NUM  per-channel ready (only the granted bit can be 1)
core_msg_d  out  32  to core msg_inpt_d
core_msg_vld_byte  out  4  to core msg_inpt_vld_byte
core_msg_vld  out  1  to core msg_inpt_vld
core_msg_lst  out  1  to core msg_inpt_lst
core_msg_rdy  in  1  from core msg_inpt_rdy
core_res  in  256  from core cmprss_otpt_res
core_res_vld  in  1  from core cmprss_otpt_vld (single-cycle pulse)
res_d  out  256  registered digest
res_vld  out  CH_NUM  one-hot, one-cycle digest-valid strobe
res_ch  out  CW  channel index of res_d
busy  out  1  state != IDLE

Behaviour:
- Beat transfer: ch_msg_vld[g] & core_msg_rdy while in XFER, where g = grant_q.
- FSM states: IDLE, XFER, WAIT_RES.
- IDLE:
  - If any ch_msg_vld is set, grant_q <= arbitration winner, next state XFER.
  - Otherwise stay in IDLE.
  - No beat is accepted in IDLE; all ch_msg_rdy = 0.
- XFER:
  - core_msg_d, core_msg_vld_byte, core_msg_vld and core_msg_lst are a combinational mux of channel g.
  - ch_msg_rdy[g] = core_msg_rdy; all other ch_msg_rdy bits = 0.
  - Transfer with ch_msg_lst[g] = 1 -> WAIT_RES.
  - The source may drop vld mid-message: grant is held, core_msg_vld follows (0). There is no timeout.
- WAIT_RES:
  - core_msg_vld = 0, all ch_msg_rdy = 0.
  - On core_res_vld: res_d <= core_res, res_ch <= g, res_vld <= one-hot(g) for exactly one cycle.
  - Also on core_res_vld: round-robin pointer <= g+1 (wraps CH_NUM-1 -> 0), next state IDLE.
- Outside XFER, core_msg_vld, core_msg_lst, core_msg_d and core_msg_vld_byte are driven to 0.
- core_res_vld seen in IDLE or XFER is ignored (no strobe, no state change).
- Round-robin arbitration: search ch_msg_vld starting at pointer, ascending, wrapping. Pointer resets to 0.
- Latency:
  - Request in IDLE to first possible transfer: 1 cycle (grant registered).
  - core_res_vld to res_vld: 1 cycle.
  - Minimum IDLE dwell between messages: 1 cycle.
- Simultaneous events: a channel asserting vld in the same cycle the FSM returns to IDLE is arbitrated on the next cycle with the updated pointer.
- Reset values: state=IDLE, grant_q=0, pointer=0, res_d=0, res_vld=0, res_ch=0, busy=0, all ch_msg_rdy=0, all core_msg_* = 0.
- Asserting rst_n low mid-message aborts immediately to reset values. The core is on the same reset.

Optional Feature:
SM3_ARB_FIX_PRIO_EN
- Defined: fixed priority, lowest index wins. The round-robin pointer is not implemented and is held at 0.
- Undefined (default): round-robin as above.
- Grant locking, routing and latency are identical in both modes.

Test Plan:
- Single 'abc' on ch2: word 32'h61626300, vld_byte 4'b1110, lst=1 -> exactly one beat reaches the core. Then res_vld=4'b0100, res_ch=2, res_d=256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0.
- 16 words 32'h61626364 on ch1, lst on word 16, core_msg_rdy toggled 1-of-3 cycles -> all 16 beats forwarded in order with none dropped. res_ch=1, res_d=256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732.
- All 4 channels request 'abc' simultaneously from reset -> grant and res_ch sequence 0,1,2,3. Each res_vld is one-hot, and no core_msg_vld occurs while busy in WAIT_RES.
- After ch3 is served, ch0 and ch3 both request -> ch0 first (pointer wrapped to 0), then ch3. With SM3_ARB_FIX_PRIO_EN and ch1/ch2 requesting, ch1 is always first.
- Ch0 drops vld for 5 cycles mid-message while ch1 requests -> ch1 rdy stays 0 until ch0's digest is returned. ch0's digest matches the C model.
- rst_n pulsed low during ch2's XFER -> all outputs return to reset values asynchronously. A new 'abc' on ch2 afterwards yields the correct digest.
